// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner sequencer for a shared 4:1 mux: grants one requester at a
// time, bounds each tenure to MAX_HOLD cycles and drives the mux selects.
module mux4_rr_arbiter #(
    parameter  int MAX_HOLD = 4,
    localparam int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    output logic [3:0]    gnt,
    output logic          s1,
    output logic          s2,
    output logic          busy,
    output logic [CW-1:0] hold_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    state_t     r_state;
    logic [1:0] r_owner;
    logic [1:0] r_ptr;

    logic       w_any;
    logic       w_keep;
    logic [1:0] w_next_ptr;
    logic [1:0] w_win_idle;
    logic [1:0] w_win_rel;

    // Scans from the highest offset down so the lowest offset from p wins.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        w_any      = |req;
        w_keep     = req[r_owner] && (hold_cnt != HOLD_LAST);
        w_next_ptr = r_owner + 2'd1;
        w_win_idle = pick(req, r_ptr);
        w_win_rel  = pick(req, w_next_ptr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_owner  <= 2'd0;
            r_ptr    <= 2'd0;
            gnt      <= 4'b0000;
            s1       <= 1'b0;
            s2       <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state  <= GRANT;
                        r_owner  <= w_win_idle;
                        gnt      <= 4'b0001 << w_win_idle;
                        {s1, s2} <= w_win_idle;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (w_keep) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end else begin
                        r_ptr    <= w_next_ptr;
                        hold_cnt <= '0;
                        if (w_any) begin
                            // Handoff in the same edge; the old owner sits last in the search.
                            r_owner  <= w_win_rel;
                            gnt      <= 4'b0001 << w_win_rel;
                            {s1, s2} <= w_win_rel;
                        end else begin
                            r_state <= IDLE;
                            gnt     <= 4'b0000;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed + random bench for mux4_rr_arbiter with a reference model feeding
// an expected-output queue; the shared mux d is modelled from the selects.
module tb_mux4_rr_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CW       = $clog2(MAX_HOLD + 1);
    localparam int EW       = 4 + 2 + 1 + CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    req = 4'b0000;
    logic [3:0]    gnt;
    logic          s1, s2, busy;
    logic [CW-1:0] hold_cnt;
    logic [3:0]    i_vec = 4'b0000;
    logic          d;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] exp_q[$];

    // reference model state
    logic          m_busy;
    logic [1:0]    m_owner, m_ptr, m_s;
    logic [3:0]    m_gnt;
    logic [CW-1:0] m_hold;

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .s1(s1), .s2(s2), .busy(busy), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    assign d = i_vec[{s1, s2}];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] first_from(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (r[idx]) return idx;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_owner = 2'd0; m_ptr = 2'd0; m_s = 2'd0;
        m_gnt = 4'b0000; m_hold = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [3:0] r);
        if (!m_busy) begin
            if (r != 4'b0000) begin
                m_owner = first_from(r, m_ptr);
                m_busy = 1'b1; m_hold = '0;
            end
        end else if (r[m_owner] && (int'(m_hold) < MAX_HOLD - 1)) begin
            m_hold = m_hold + CW'(1);
        end else begin
            m_ptr = m_owner + 2'd1;
            m_hold = '0;
            if (r != 4'b0000) m_owner = first_from(r, m_ptr);
            else m_busy = 1'b0;
        end
        if (m_busy) begin
            m_gnt = 4'b0001 << m_owner;
            m_s   = m_owner;
        end else begin
            m_gnt = 4'b0000;
        end
        exp_q.push_back({m_gnt, m_s, m_busy, m_hold});
    endtask

    task automatic check_inv();
        logic [1:0] gidx;
        gidx = 2'd0;
        for (int k = 0; k < 4; k++) if (gnt[k]) gidx = 2'(k);
        chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
        chk("inv_busy", 32'(gnt != 4'b0000), 32'(busy));
        chk("inv_hold", 32'(int'(hold_cnt) <= MAX_HOLD - 1), 32'd1);
        if (busy) begin
            chk("inv_sel", 32'({s1, s2}), 32'(gidx));
            chk("d_owner", 32'(d), 32'(i_vec[gidx]));
        end
    endtask

    // Called between edges: drive req, predict, then sample 1 time unit after the edge.
    task automatic step(input logic [3:0] r);
        logic [EW-1:0] e;
        req = r;
        i_vec = 4'($urandom_range(0, 15));
        model_step(r);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("sb", 32'({gnt, s1, s2, busy, hold_cnt}), 32'(e));
        end
        check_inv();
    endtask

    task automatic reset_pulse(input logic [3:0] r);
        rst_n = 1'b0;
        req = r;
        #1;
        model_reset();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'({s1, s2}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_hold", 32'(hold_cnt), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: reset with all requests high, then first grant
        req = 4'b1111;
        @(posedge clk);
        #1;
        reset_pulse(4'b1111);
        step(4'b1111);
        i_vec = 4'b0001;
        #1;
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_sel", 32'({s1, s2}), 32'h0);
        chk("t1_d", 32'(d), 32'h1);

        // 2: rotation with MAX_HOLD-cycle tenures, no bubbles
        for (int k = 1; k <= 16; k++) begin
            step(4'b1111);
            chk("t2_gnt", 32'(gnt), 32'(4'b0001 << ((k / MAX_HOLD) % 4)));
            chk("t2_busy", 32'(busy), 32'h1);
        end

        // 3: early release of owner 2 hands to 3
        reset_pulse(4'b0000);
        step(4'b0100);
        step(4'b0100);
        chk("t3_pre", 32'(gnt), 32'h4);
        step(4'b1001);
        chk("t3_gnt", 32'(gnt), 32'h8);
        chk("t3_hold", 32'(hold_cnt), 32'h0);

        // 4: sole requester times out and is re-granted
        reset_pulse(4'b0000);
        for (int k = 0; k < MAX_HOLD; k++) begin
            step(4'b0010);
            chk("t4_gnt", 32'(gnt), 32'h2);
            chk("t4_hold", 32'(hold_cnt), 32'(k));
        end
        step(4'b0010);
        chk("t4_regrant", 32'(gnt), 32'h2);
        chk("t4_rehold", 32'(hold_cnt), 32'h0);
        chk("t4_busy", 32'(busy), 32'h1);

        // 5: go idle from owner 1, selects hold, restart from ptr=2
        step(4'b0000);
        chk("t5_gnt", 32'(gnt), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_sel", 32'({s1, s2}), 32'h1);
        step(4'b0000);
        chk("t5_sel2", 32'({s1, s2}), 32'h1);
        step(4'b0101);
        chk("t5_restart", 32'(gnt), 32'h4);

        // 6: async reset between edges while owner 3 holds
        step(4'b1000);
        chk("t6_pre", 32'(gnt), 32'h8);
        reset_pulse(4'b0000);
        step(4'b1001);
        chk("t6_gnt", 32'(gnt), 32'h1);

        // random traffic against the model
        for (int n = 0; n < 300; n++) begin
            step(4'($urandom_range(0, 15)));
            if (n % 97 == 96) reset_pulse(4'b0000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
